axi_wr_engine: RTL and testbench

- Write-channel engine of the AXI bridge, directly downstream of the data cache's write port.
- Captures one dirty-line writeback (INCR burst) or one uncached single store into a single-entry buffer.
- Drives AXI3 AW/W/B to completion and reports wr_idle so the read arbiter can hold AR issue while a write is outstanding.

---
 rtl/axi_wr_engine_pkg.sv | 19 +
 rtl/axi_wr_beat_sel.sv | 22 ++
 rtl/axi_wr_engine.sv | 169 ++++++++++++++++
 tb/tb_axi_wr_engine.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_wr_engine_pkg.sv
// Shared types and constants for the AXI write-channel engine.
// AXI burst/size codes, the engine ID and the FSM state encoding.
package axi_wr_engine_pkg;

  localparam logic [1:0] BURST_FIXED   = 2'b00;
  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD = 3'b010;
  localparam logic [3:0] AXI_ID        = 4'd1;

  // Beat counter width: a line holds at most 16 words.
  localparam int BEAT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_RESP
  } state_t;

endpackage

// File: rtl/axi_wr_beat_sel.sv
// Word-select mux: picks 32-bit word i_idx out of the buffered line.
// Ports: i_line (line data), i_idx (beat index), o_word (selected word).
module axi_wr_beat_sel
  import axi_wr_engine_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic [WORDS*32-1:0] i_line,
  input  logic [BEAT_W-1:0]   i_idx,
  output logic [31:0]         o_word
);

  always_comb begin
    o_word = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (i_idx == i[BEAT_W-1:0]) begin
        o_word = i_line[32*i +: 32];
      end
    end
  end

endmodule

// File: rtl/axi_wr_engine.sv
// AXI3 write engine: buffers one dcache line writeback or uncached store
// and drives AW/W/B to completion.
// Ports: clk/reset; dcache side wr_req/wr_rdy/burst/data/addr/size/strb,
// read_unfinish, wr_idle; AXI AW (aw*), W (w*) and B (b*) channels.
module axi_wr_engine
  import axi_wr_engine_pkg::*;
#(
  parameter int D_BYTES_PER_LINE = 16,
  parameter int D_WORDS_PER_LINE = D_BYTES_PER_LINE / 4,
  parameter int D_LINE_WIDTH     = D_WORDS_PER_LINE * 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_req,
  output logic                    wr_rdy,
  input  logic                    burst,
  input  logic [D_LINE_WIDTH-1:0] data,
  input  logic [31:0]             addr,
  input  logic [1:0]              size,
  input  logic [3:0]              strb,
  input  logic                    read_unfinish,
  output logic                    wr_idle,
  output logic [3:0]              awid,
  output logic [31:0]             awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic [1:0]              awlock,
  output logic [3:0]              awcache,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [3:0]              wid,
  output logic [31:0]             wdata,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [3:0]              bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam logic [7:0] LINE_LEN = 8'(D_WORDS_PER_LINE - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_burst;
  logic [31:0]             r_addr;
  logic [D_LINE_WIDTH-1:0] r_data;
  logic [1:0]              r_size;
  logic [3:0]              r_strb;
  logic [BEAT_W-1:0]       r_cnt;
  logic                    r_aw_done;
  logic                    r_w_done;

  logic        w_xfer;
  logic        w_accept;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_at_last;
  logic [31:0] w_word;
  logic        w_unused;

  // Response contents are not acted on; errors are not retried.
  assign w_unused = ^{bid, bresp};

  assign w_xfer    = (r_state == S_XFER);
  assign w_accept  = wr_req & wr_rdy;
  assign w_aw_hs   = w_xfer & ~r_aw_done & awready;
  assign w_w_hs    = w_xfer & ~r_w_done & wready;
  assign w_at_last = (r_cnt == awlen[BEAT_W-1:0]);

  always_comb begin
    w_next  = r_state;
    wr_rdy  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        wr_rdy = ~read_unfinish;
        if (wr_req & ~read_unfinish) begin
          w_next = S_XFER;
        end
      end
      S_XFER: begin
        awvalid = ~r_aw_done;
        wvalid  = ~r_w_done;
        // Both channels done, counting a same-cycle handshake.
        if ((r_aw_done | w_aw_hs) &
            (r_w_done | (w_w_hs & w_at_last))) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt     <= '0;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_aw_hs) begin
          r_aw_done <= 1'b1;
        end
        // Counter parks on the last beat so wdata stays put.
        if (w_w_hs) begin
          if (w_at_last) begin
            r_w_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_burst <= burst;
      r_addr  <= addr;
      r_data  <= data;
      r_size  <= size;
      r_strb  <= strb;
    end
  end

  axi_wr_beat_sel #(
    .WORDS (D_WORDS_PER_LINE)
  ) u_beat_sel (
    .i_line (r_data),
    .i_idx  (r_cnt),
    .o_word (w_word)
  );

  assign wr_idle = (r_state == S_IDLE);

  assign awid    = AXI_ID;
  assign awaddr  = r_addr;
  assign awlen   = r_burst ? LINE_LEN : 8'd0;
  assign awsize  = r_burst ? AXI_SIZE_WORD : {1'b0, r_size};
  assign awburst = r_burst ? BURST_INCR : BURST_FIXED;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;

  assign wid   = AXI_ID;
  assign wdata = w_word;
  assign wstrb = r_burst ? 4'hF : r_strb;
  assign wlast = wvalid & w_at_last;

endmodule

// File: tb/tb_axi_wr_engine.sv
// Scoreboard bench for axi_wr_engine: expected AW/W beats are queued at
// acceptance and popped by a monitor on each channel handshake.
module tb_axi_wr_engine;

  localparam int WORDS = 4;
  localparam int LW    = WORDS * 32;

  logic          clk;
  logic          reset;
  logic          wr_req;
  logic          wr_rdy;
  logic          burst;
  logic [LW-1:0] data;
  logic [31:0]   addr;
  logic [1:0]    size;
  logic [3:0]    strb;
  logic          read_unfinish;
  logic          wr_idle;
  logic [3:0]    awid;
  logic [31:0]   awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic [1:0]    awlock;
  logic [3:0]    awcache;
  logic [2:0]    awprot;
  logic          awvalid;
  logic          awready;
  logic [3:0]    wid;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wlast;
  logic          wvalid;
  logic          wready;
  logic [3:0]    bid;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;

  axi_wr_engine #(.D_BYTES_PER_LINE(16)) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_rdy(wr_rdy), .burst(burst),
    .data(data), .addr(addr), .size(size), .strb(strb),
    .read_unfinish(read_unfinish), .wr_idle(wr_idle),
    .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } aw_exp_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_exp_t;

  aw_exp_t aw_q[$];
  w_exp_t  w_q[$];

  int checks = 0;
  int errors = 0;
  int b_hs   = 0;

  int aw_pct   = 100;
  int w_pct    = 100;
  int b_delay  = 1;
  int aw_hold  = 0;
  bit w_toggle = 0;
  bit wtog     = 1;
  bit ru_rand  = 0;
  int bcnt     = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_model(bit b, logic [31:0] a, logic [LW-1:0] d,
                            logic [1:0] sz, logic [3:0] st);
    aw_exp_t e;
    w_exp_t  w;
    e.addr  = a;
    e.len   = b ? 8'(WORDS - 1) : 8'd0;
    e.size  = b ? 3'd2 : {1'b0, sz};
    e.burst = b ? 2'b01 : 2'b00;
    aw_q.push_back(e);
    if (b) begin
      for (int i = 0; i < WORDS; i++) begin
        w.data = d[32*i +: 32];
        w.strb = 4'hF;
        w.last = (i == WORDS - 1);
        w_q.push_back(w);
      end
    end else begin
      w.data = d[31:0];
      w.strb = st;
      w.last = 1'b1;
      w_q.push_back(w);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < WORDS; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave-side responder and read_unfinish noise, updated 2 after each edge.
  initial begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bid     = 4'd0;
    bresp   = 2'd0;
    forever begin
      @(posedge clk);
      #2;
      if (aw_hold > 0) begin
        awready = 1'b0;
        aw_hold--;
      end else begin
        awready = ($urandom_range(0, 99) < aw_pct);
      end
      if (w_toggle) begin
        wready = wtog;
        wtog   = ~wtog;
      end else begin
        wready = ($urandom_range(0, 99) < w_pct);
      end
      if (bready) bcnt++;
      else bcnt = 0;
      bvalid = bready && (bcnt >= b_delay);
      bid    = 4'($urandom);
      bresp  = 2'($urandom);
      if (ru_rand) read_unfinish = 1'($urandom);
    end
  end

  // Monitor: handshake scoreboard plus payload-stability while stalled.
  logic        aw_stall, w_stall;
  logic [44:0] aw_saved;
  logic [36:0] w_saved;

  initial begin
    aw_stall = 1'b0;
    w_stall  = 1'b0;
    aw_saved = '0;
    w_saved  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        aw_stall = 1'b0;
        w_stall  = 1'b0;
      end else begin
        if (aw_stall) begin
          chk("aw_valid_held", awvalid, 1);
          chk("aw_payload_held", {awaddr, awlen, awsize, awburst}, aw_saved);
        end
        if (w_stall) begin
          chk("w_valid_held", wvalid, 1);
          chk("w_payload_held", {wdata, wstrb, wlast}, w_saved);
        end
        if (awvalid && awready) begin
          if (aw_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL aw_unexpected: got addr %0h expected none", awaddr);
          end else begin
            aw_exp_t e;
            e = aw_q.pop_front();
            chk("aw_addr", awaddr, e.addr);
            chk("aw_len", awlen, e.len);
            chk("aw_size", awsize, e.size);
            chk("aw_burst", awburst, e.burst);
            chk("aw_const", {awid, awlock, awcache, awprot}, {4'd1, 9'd0});
          end
        end
        if (wvalid && wready) begin
          if (w_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL w_unexpected: got data %0h expected none", wdata);
          end else begin
            w_exp_t w;
            w = w_q.pop_front();
            chk("w_data", wdata, w.data);
            chk("w_strb", wstrb, w.strb);
            chk("w_last", wlast, w.last);
            chk("w_id", wid, 4'd1);
          end
        end
        if (bready && bvalid) begin
          b_hs++;
          chk("b_after_aw_drained", aw_q.size(), 0);
          chk("b_after_w_drained", w_q.size(), 0);
        end
        aw_stall = awvalid & ~awready;
        aw_saved = {awaddr, awlen, awsize, awburst};
        w_stall  = wvalid & ~wready;
        w_saved  = {wdata, wstrb, wlast};
      end
    end
  end

  // Present a request; called just after a rising edge. Returns the number
  // of cycles spent waiting for wr_rdy.
  task automatic issue(bit b, logic [31:0] a, logic [LW-1:0] d,
                       logic [1:0] sz, logic [3:0] st, output int waited);
    int n;
    burst  = b;
    addr   = a;
    data   = d;
    size   = sz;
    strb   = st;
    wr_req = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (wr_rdy) break;
    end
    waited = n;
    if (n == 200) begin
      chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      wr_req = 1'b0;
      return;
    end
    push_model(b, a, d, sz, st);
    @(posedge clk);
    #1;
    wr_req = 1'b0;
    burst  = 1'($urandom);
    addr   = $urandom;
    data   = rand_line();
    size   = 2'($urandom);
    strb   = 4'($urandom);
  endtask

  task automatic wait_done(bit tchk);
    int n;
    int b0;
    bit aw_seen;
    bit rchk;
    b0      = b_hs;
    aw_seen = 0;
    rchk    = 0;
    for (n = 0; n < 500; n++) begin
      @(negedge clk);
      if (n == 0) chk("idle_low_after_accept", wr_idle, 0);
      if (tchk) begin
        if (aw_seen && !rchk) begin
          chk("resp_cycle_after_aw", bready, 1);
          rchk = 1;
        end else if (!aw_seen && bready) begin
          chk("resp_before_aw", bready, 0);
        end
        if (awvalid && awready) begin
          aw_seen = 1;
          chk("w_done_before_aw", wvalid, 0);
        end
      end
      if (wr_idle) break;
    end
    if (n == 500) chk("done_timeout", 0, 1);
    if (tchk) chk("aw_handshake_seen", aw_seen, 1);
    chk("one_b_handshake", b_hs - b0, 1);
    chk("aw_q_drained", aw_q.size(), 0);
    chk("w_q_drained", w_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int           w;
    logic [LW-1:0] line1;
    reset         = 1'b1;
    wr_req        = 1'b0;
    burst         = 1'b0;
    data          = '0;
    addr          = '0;
    size          = '0;
    strb          = '0;
    read_unfinish = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_wlast", wlast, 0);
    chk("rst_wr_idle", wr_idle, 1);
    chk("rst_wr_rdy", wr_rdy, 1);
    @(posedge clk);
    #1;

    // Line writeback, all ready.
    line1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    b_delay = 2;
    issue(1, 32'h1C000040, line1, 2'd0, 4'h0, w);
    wait_done(0);

    // Uncached byte store.
    issue(0, 32'hBFAF8001, {96'd0, 32'h0000AB00}, 2'd0, 4'b0010, w);
    wait_done(0);

    // AW stalled 5 cycles: W finishes first, RESP follows AW.
    aw_hold = 5;
    issue(1, 32'h00001230, rand_line(), 2'd0, 4'h0, w);
    wait_done(1);

    // wready alternating.
    w_toggle = 1;
    wtog     = 1;
    issue(1, 32'h80000100, rand_line(), 2'd0, 4'h0, w);
    wait_done(0);
    w_toggle = 0;

    // read_unfinish blocks acceptance; drop releases it at once.
    read_unfinish = 1'b1;
    fork
      issue(1, 32'h00004440, rand_line(), 2'd0, 4'h0, w);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("ru_blocks_rdy", wr_rdy, 0);
          chk("ru_nothing_taken", wr_idle, 1);
        end
        @(posedge clk);
        #1;
        read_unfinish = 1'b0;
      end
    join
    chk("accept_when_ru_drops", w, 3);
    wait_done(0);

    // Reset while beat 2 of a burst is on the bus.
    issue(1, 32'h0000ABC0, rand_line(), 2'd0, 4'h0, w);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    aw_q.delete();
    w_q.delete();
    @(negedge clk);
    chk("midrst_awvalid", awvalid, 0);
    chk("midrst_wvalid", wvalid, 0);
    chk("midrst_bready", bready, 0);
    chk("midrst_wr_idle", wr_idle, 1);
    chk("midrst_wr_rdy", wr_rdy, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Randomized traffic with read_unfinish noise during transfers.
    ru_rand = 1;
    repeat (40) begin
      bit b;
      aw_pct  = $urandom_range(30, 100);
      w_pct   = $urandom_range(30, 100);
      b_delay = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) aw_hold = $urandom_range(1, 6);
      b = 1'($urandom);
      issue(b, b ? {$urandom_range(0, 32'h0FFFFFFF), 4'h0} : $urandom,
            rand_line(), 2'($urandom_range(0, 2)), 4'($urandom), w);
      wait_done(0);
    end
    ru_rand       = 0;
    read_unfinish = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
